stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with a registered output and valid/ready handshakes on every port. It merges several producer streams onto one consumer link. Channel choice is either an external select or round-robin arbitration. Once a channel is granted, it is locked until its packet ends (`in_last`), so packets are never interleaved.

## Interface
- `N_CH`, default 4: number of input channels, ≥2. Local `SEL_W = $clog2(N_CH)`.
- `W`, default 8: data width per channel, ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mode`  in  1  0 = SEL (external select), 1 = RR (round-robin).
- `sel`  in  SEL_W  channel chosen in SEL mode. Values ≥ N_CH grant nothing.
- `in_valid`  in  N_CH  per-channel valid.
- `in_data`  in  N_CH*W  channel i occupies bits [i*W +: W].
- `in_last`  in  N_CH  per-channel end-of-packet flag.
- `in_ready`  out  N_CH  per-channel ready; at most one bit is high.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered data.
- `out_last`  out  1  registered last flag.
- `out_ch`  out  SEL_W  source channel of the current output beat.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- Output register capacity is one beat.
  - `load_en = !out_valid || out_ready`.
  - A beat from channel g transfers when `in_valid[g] && in_ready[g]`.
  - `in_ready[g] = load_en && grant[g]`.
- FSM states: IDLE (no packet open), LOCKED (channel `lock_ch` has an open packet).
- IDLE grant selection:
  - SEL mode: grant = `sel` if `sel < N_CH` and `in_valid[sel]`; otherwise no grant.
  - RR mode: grant = first valid channel, searching upward from `rr_ptr` and wrapping modulo N_CH.
- IDLE transitions:
  - Transfer with `in_last=0` → LOCKED, `lock_ch <= g`.
  - Transfer with `in_last=1` → stays IDLE (single-beat packet).
- LOCKED:
  - Grant is fixed to `lock_ch`. `mode`, `sel` and other channels' valids are ignored.
  - A transfer with `in_last=1` → IDLE.
- Round-robin pointer: on each transfer with `in_last=1`, in either mode, `rr_ptr <= (g+1) mod N_CH`. Packet-granular fairness.
- Any transfer: `out_data`, `out_last`, `out_ch` and `out_valid=1` load next edge.
- `out_ready` high with no transfer: `out_valid <= 0`.
- Simultaneous consume and load: register reloads in the same cycle. Full throughput, no bubble.
- `mode`/`sel` changes take effect only in IDLE.
- With no grant, all `in_ready` bits are 0.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_ch=0`, state IDLE, `rr_ptr=0`, `lock_ch=0`. `in_ready=0` during reset.
- Reset asserted mid-packet: all state cleared immediately; any in-flight beat is dropped. After release the block is in IDLE with `rr_ptr=0`.
- Latency: input transfer at edge k → `out_valid` and data visible after edge k. One cycle.
- `in_ready` is combinational from `out_ready`, `out_valid`, `in_valid`, state, `mode`, `sel`. No combinational path from `in_data` to any output.
- Sustained throughput: one beat per cycle while `out_ready=1`.
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_last` and `out_ch` hold.
- Producers must hold `in_valid`, `in_data` and `in_last` until their transfer completes; `in_valid` must not depend on `in_ready`.

## Structure
- Package `stream_mux_pkg`: mode constants `MODE_SEL=1'b0`, `MODE_RR=1'b1`; state enum {`ST_IDLE`, `ST_LOCKED`}.
- Sub-module `rr_arbiter`:
  - Parameter N; inputs `req[N]`, `ptr[$clog2(N)]`.
  - Output one-hot `gnt[N]` plus binary index; purely combinational.
  - Instantiated once; the SEL path bypasses it.
- Top level holds the FSM, `rr_ptr`, `lock_ch`, the output register and the W-wide N:1 data mux.

## Test plan
All scenarios use N_CH=4, W=8.
- Reset/idle: `rst_n=0`, all inputs random → `out_valid=0`, `out_data=0`, `in_ready=4'b0000`. Release with `in_valid=0` → nothing changes.
- SEL single beats: `mode=0`, `sel=2`, `in_valid=4'b1111`, `in_last=4'b1111`, ch2 data 8'hA5, `out_ready=1` → `in_ready=4'b0100`; next cycle `out_data=8'hA5`, `out_ch=2`; one beat per cycle.
- RR fairness: `mode=1`, all channels valid with single-beat packets, `out_ready=1` → `out_ch` sequence 0,1,2,3,0.
- Packet lock: `mode=1`, ch1 sends a 3-beat packet (last on beat 3) while ch0, ch2 and ch3 are valid; `sel`/`mode` toggled mid-packet → three consecutive ch1 beats, then grant to ch2.
- Backpressure: `out_ready=0` for 5 cycles with `out_valid=1` → `out_data` held, `in_ready=0`. Raise `out_ready` → the next beat loads in the same cycle, no bubble.
- Reset mid-packet: assert `rst_n=0` during a ch3 packet → outputs at reset values immediately. After release with all channels valid in RR mode → first grant is ch0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
// Imported by the top level for mode decoding and FSM state typing.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for the stream multiplexer: N producer channels in, one consumer link out.
// The slave modport is the multiplexer's view; master is the surrounding environment.
interface stream_mux_rr_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
) ();
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_last;
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic [SEL_W-1:0]  out_ch;
    logic              out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo N.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic          w_found;
    logic [PW-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = PW'((int'(ptr) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream multiplexer with a one-beat registered output.
// A granted channel stays locked until its last beat so packets never interleave.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int  N_CH  = 4,
    parameter int  W     = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    stream_mux_rr_if.slave   bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] r_lock_ch;

    logic [N_CH-1:0]  w_arb_gnt;
    logic [SEL_W-1:0] w_arb_idx;
    logic [N_CH-1:0]  w_gnt;
    logic [SEL_W-1:0] w_gidx;
    logic [N_CH-1:0]  w_ready;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_last_sel;
    logic [W-1:0]     w_data_sel;
    logic [SEL_W-1:0] w_ptr_nxt;

    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic             r_out_last;
    logic [SEL_W-1:0] r_out_ch;

    rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .req (bus.in_valid),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx)
    );

    // Grant source: locked channel, else arbiter (RR) or external select (SEL)
    always_comb begin
        w_gnt  = '0;
        w_gidx = '0;
        if (r_state == ST_LOCKED) begin
            w_gnt[r_lock_ch] = 1'b1;
            w_gidx           = r_lock_ch;
        end else if (mode == MODE_RR) begin
            w_gnt  = w_arb_gnt;
            w_gidx = w_arb_idx;
        end else if (int'(sel) < N_CH && bus.in_valid[sel]) begin
            w_gnt[sel] = 1'b1;
            w_gidx     = sel;
        end
    end

    assign w_load_en    = !r_out_valid || bus.out_ready;
    assign w_ready      = (rst_n && w_load_en) ? w_gnt : '0;
    assign bus.in_ready = w_ready;
    assign w_xfer       = |(bus.in_valid & w_ready);
    assign w_last_sel   = bus.in_last[w_gidx];
    assign w_data_sel   = bus.in_data[w_gidx*W +: W];
    assign w_ptr_nxt    = (w_gidx == SEL_W'(N_CH - 1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = w_last_sel ? ST_IDLE : ST_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                if (w_last_sel) begin
                    r_rr_ptr <= w_ptr_nxt;
                end else begin
                    r_lock_ch <= w_gidx;
                end
            end
        end
    end

    // Output register reloads on the same edge it is consumed, so no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data_sel;
            r_out_last  <= w_last_sel;
            r_out_ch    <= w_gidx;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N_CH=4, W=8) against a packet-level reference model.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    int         n_checks;
    int         n_fail;

    stream_mux_rr_if #(.N_CH(4), .W(8)) bus ();

    stream_mux_rr #(.N_CH(4), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: open packet owner (-1 = none), fairness pointer, output beat
    int         m_lock;
    int         m_ptr;
    logic       m_ov;
    logic [7:0] m_od;
    logic       m_ol;
    logic [1:0] m_och;
    logic [3:0] exp_rdy;
    logic [3:0] obs_rdy;

    function automatic void m_reset();
        m_lock = -1;
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_od   = 8'h00;
        m_ol   = 1'b0;
        m_och  = 2'd0;
    endfunction

    function automatic int m_grant();
        if (m_lock >= 0) return m_lock;
        if (mode == MODE_RR) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (bus.in_valid[c]) return c;
            end
            return -1;
        end
        if (bus.in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int         g;
        r = 4'b0000;
        if (!rst_n) return r;
        g = m_grant();
        if ((!m_ov || bus.out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void m_clock();
        int g;
        g = m_grant();
        if ((!m_ov || bus.out_ready) && g >= 0 && bus.in_valid[g]) begin
            m_ov  = 1'b1;
            m_od  = bus.in_data[g*8 +: 8];
            m_ol  = bus.in_last[g];
            m_och = 2'(g);
            if (bus.in_last[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % 4;
            end else begin
                m_lock = g;
            end
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        exp_rdy = m_ready();
        obs_rdy = bus.in_ready;
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_clock();
        #1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < 4; c++) bus.in_data[c*8 +: 8] = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        m_reset();
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        m_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 4'($urandom);
            bus.in_last   = 4'($urandom);
            bus.out_ready = 1'($urandom);
            mode          = 1'($urandom);
            sel           = 2'($urandom);
            rand_data();
            tick();
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_hold: rdy=%b v=%b d=%h, want all zero", obs_rdy, bus.out_valid, bus.out_data);
            end
        end
        bus.in_valid = 4'b0000;
        rst_n        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
                n_fail++;
                $display("FAIL reset_release: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d",
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
            end
        end
    endtask

    task automatic test_sel_single();
        mode          = MODE_SEL;
        sel           = 2'd2;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        rand_data();
        bus.in_data[23:16] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_ch} !== {4'b0100, 1'b1, 8'hA5, 2'd2}) begin
                n_fail++;
                $display("FAIL sel_beat: got rdy=%b v=%b d=%h ch=%0d, want rdy=0100 v=1 d=a5 ch=2",
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_ch);
            end
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
                n_fail++;
                $display("FAIL sel_model: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d",
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
            end
        end
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        mode          = MODE_RR;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            tick();
            n_checks++;
            if (bus.out_ch !== exp_seq[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got ch=%0d v=%b, want ch=%0d v=1", i, bus.out_ch, bus.out_valid, exp_seq[i]);
            end
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
                n_fail++;
                $display("FAIL rr_model: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d",
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] d [3];
        logic [1:0] exp_ch [4];
        exp_ch = '{2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
        mode          = MODE_RR;
        bus.out_ready = 1'b1;
        bus.in_last   = 4'b1101;
        rand_data();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = (i == 0) ? 4'b0010 : 4'b1111;
            if (i < 3) bus.in_data[15:8] = d[i];
            bus.in_last[1] = (i >= 2);
            if (i == 1) begin mode = MODE_SEL; sel = 2'd3; end
            if (i == 2) begin mode = MODE_RR;  sel = 2'd0; end
            tick();
            n_checks++;
            if (bus.out_ch !== exp_ch[i] || (i < 3 && bus.out_data !== d[i])) begin
                n_fail++;
                $display("FAIL lock_beat[%0d]: got ch=%0d d=%h, want ch=%0d d=%h", i, bus.out_ch, bus.out_data, exp_ch[i],
                         (i < 3) ? d[i] : bus.in_data[23:16]);
            end
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
                n_fail++;
                $display("FAIL lock_model: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d",
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        held          = m_od;
        mode          = MODE_RR;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b0;
        rand_data();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs_rdy !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h, want rdy=0000 v=1 d=%h", i, obs_rdy, bus.out_valid, bus.out_data, held);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (obs_rdy !== 4'b1000 || bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== bus.in_data[31:24]) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b v=%b ch=%0d d=%h, want rdy=1000 v=1 ch=3 d=%h",
                     obs_rdy, bus.out_valid, bus.out_ch, bus.out_data, bus.in_data[31:24]);
        end
        n_checks++;
        if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
            n_fail++;
            $display("FAIL bp_model: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d",
                     obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
        end
    endtask

    task automatic test_random();
        logic [3:0] pend;
        pend = 4'b0000;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c]               = 1'b1;
                    bus.in_data[c*8 +: 8] = 8'($urandom);
                    bus.in_last[c]        = ($urandom_range(0, 2) == 0);
                end
            end
            bus.in_valid  = pend;
            mode          = 1'($urandom);
            sel           = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
                n_fail++;
                $display("FAIL random[%0d]: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d", i,
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
            end
            pend = pend & ~(exp_rdy & pend);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode          = MODE_SEL;
        sel           = 2'd3;
        bus.in_valid  = 4'b1000;
        bus.in_last   = 4'b0000;
        bus.out_ready = 1'b1;
        rand_data();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_first_beat: got v=%b ch=%0d, want v=1 ch=3", bus.out_valid, bus.out_ch);
        end
        rand_data();
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b v=%b d=%h l=%b ch=%0d, want all zero",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch);
        end
        tick();
        rst_n        = 1'b1;
        mode         = MODE_RR;
        bus.in_valid = 4'b1111;
        bus.in_last  = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(i) || obs_rdy !== (4'b0001 << i)) begin
                n_fail++;
                $display("FAIL mid_regrant[%0d]: got v=%b ch=%0d rdy=%b, want v=1 ch=%0d", i, bus.out_valid, bus.out_ch, obs_rdy, i);
            end
            n_checks++;
            if ({obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch} !== {exp_rdy, m_ov, m_od, m_ol, m_och}) begin
                n_fail++;
                $display("FAIL mid_model: got rdy=%b v=%b d=%h l=%b ch=%0d, want rdy=%b v=%b d=%h l=%b ch=%0d",
                         obs_rdy, bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, exp_rdy, m_ov, m_od, m_ol, m_och);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        mode          = MODE_SEL;
        sel           = 2'd0;
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sel_single();
        test_rr_fair();
        test_packet_lock();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
